// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter: fixed m0 priority, m1 wins after MAX_WAIT lost contests.
// Define ARB_TIMEOUT_EN to add the per-access timeout counter and busErr strobe.
`timescale 1ns/1ps

`ifndef MEM_ACCESS_T
`define MEM_ACCESS_T    [1:0]
`define MEM_ACCESS_NONE 2'd0
`define MEM_ACCESS_R    2'd1
`define MEM_ACCESS_W    2'd2
`define MEM_ACCESS_X    2'd3
`endif

module mem_bus_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                res,
  input  logic [31:0]         m0_addr,
  input  logic `MEM_ACCESS_T  m0_accessType,
  input  logic [31:0]         m0_dataOut,
  output logic [31:0]         m0_dataIn,
  output logic                m0_ready,
  input  logic [31:0]         m1_addr,
  input  logic `MEM_ACCESS_T  m1_accessType,
  input  logic [31:0]         m1_dataOut,
  output logic [31:0]         m1_dataIn,
  output logic                m1_ready,
  output logic [31:0]         s_addr,
  output logic `MEM_ACCESS_T  s_accessType,
  output logic [31:0]         s_dataOut,
  input  logic [31:0]         s_dataIn,
  input  logic                s_ready,
  output logic [1:0]          grant,
  output logic                busErr
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_GNT0 = 2'b01,
    S_GNT1 = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                m0_req, m1_req;
  logic                own_req, own_done;
  logic [31:0]         own_addr, own_wdata, own_rdata;
  logic `MEM_ACCESS_T  own_type;

  if (MAX_WAIT == 0 || TIMEOUT == 0) begin : g_param_check
    $error("mem_bus_arbiter: MAX_WAIT and TIMEOUT must be >= 1");
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  logic [TMO_W-1:0]    tmo_q, tmo_d;
`endif

  assign m0_req = (m0_accessType != `MEM_ACCESS_NONE);
  assign m1_req = (m1_accessType != `MEM_ACCESS_NONE);
  assign grant  = state_q;

  always_comb begin
    if (state_q == S_GNT1) begin
      own_addr  = m1_addr;
      own_type  = m1_accessType;
      own_wdata = m1_dataOut;
    end else begin
      own_addr  = m0_addr;
      own_type  = m0_accessType;
      own_wdata = m0_dataOut;
    end
  end

  assign own_req = (own_type != `MEM_ACCESS_NONE);

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
`ifdef ARB_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    own_done     = 1'b0;
    own_rdata    = s_dataIn;
    busErr       = 1'b0;
    s_addr       = '0;
    s_accessType = `MEM_ACCESS_NONE;
    s_dataOut    = '0;
`ifdef ARB_TIMEOUT_EN
    tmo_d        = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (m0_req && m1_req) begin
          if (wait_q == WAIT_MAX) begin
            state_d = S_GNT1;
            wait_d  = '0;
          end else begin
            state_d = S_GNT0;
            wait_d  = wait_q + 1'b1;
          end
        end else if (m0_req) begin
          state_d = S_GNT0;
        end else if (m1_req) begin
          state_d = S_GNT1;
          wait_d  = '0;
        end
      end
      S_GNT0, S_GNT1: begin
        // An owner dropping its request is an abort: its NONE type passes straight through.
        s_addr       = own_addr;
        s_accessType = own_type;
        s_dataOut    = own_wdata;
        own_done     = own_req && s_ready;
`ifdef ARB_TIMEOUT_EN
        tmo_d = s_ready ? tmo_q : tmo_q + 1'b1;
        if (own_req && !s_ready && tmo_q == TMO_MAX) begin
          own_done     = 1'b1;
          own_rdata    = 32'hDEAD_BEEF;
          busErr       = 1'b1;
          s_accessType = `MEM_ACCESS_NONE;
        end
`endif
        if (!own_req || own_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_dataIn = '0;
    m1_dataIn = '0;
    if (state_q == S_GNT0) begin
      m0_ready  = own_done;
      m0_dataIn = own_rdata;
    end
    if (state_q == S_GNT1) begin
      m1_ready  = own_done;
      m1_dataIn = own_rdata;
    end
  end

endmodule
